// File: rtl/bp_me_cfg_boot_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bp_me_cfg_boot_sequencer_pkg
//   Shared definitions for the configuration boot sequencer. This file holds the
//   BedRock memory header layout and message enums, the config-slice register
//   offsets, the LCE/CCE mode values and the sequencer state enum.
//   Optional feature macro: BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN adds the
//   microcode readback state (e_seq_ucode_rd).
// -----------------------------------------------------------------------------
package bp_me_cfg_boot_sequencer_pkg;

  localparam int paddr_width_gp     = 40;
  localparam int cce_instr_width_gp = 64;

  // Config-slice register map
  localparam logic [paddr_width_gp-1:0] cfg_reg_freeze_gp           = 40'h00_0000_0008;
  localparam logic [paddr_width_gp-1:0] cfg_reg_npc_gp              = 40'h00_0000_0010;
  localparam logic [paddr_width_gp-1:0] cfg_reg_icache_mode_gp      = 40'h00_0000_0200;
  localparam logic [paddr_width_gp-1:0] cfg_reg_dcache_mode_gp      = 40'h00_0000_0400;
  localparam logic [paddr_width_gp-1:0] cfg_reg_cce_mode_gp         = 40'h00_0000_0600;
  localparam logic [paddr_width_gp-1:0] cfg_mem_cce_ucode_match_gp  = 40'h00_0000_8000;

  localparam logic [63:0] boot_base_addr_gp = 64'h0000_0000_0011_0000;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic [1:0] {
    e_cce_mode_uncached = 2'd0,
    e_cce_mode_normal   = 2'd1
  } bp_cce_mode_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [15:0]                 payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    logic [3:0]                  subop;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [3:0] {
    e_seq_idle,
    e_seq_freeze,
    e_seq_rom,
    e_seq_ucode_wr,
`ifdef BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN
    e_seq_ucode_rd,
`endif
    e_seq_icache,
    e_seq_dcache,
    e_seq_cce,
    e_seq_npc,
    e_seq_unfreeze,
    e_seq_wait,
    e_seq_done,
    e_seq_error
  } bp_cfg_seq_state_e;

endpackage

// File: rtl/bp_me_cfg_boot_sequencer_cmd_gen.sv
// -----------------------------------------------------------------------------
// bp_me_cfg_seq_cmd_gen
//   Purely combinational command builder: maps the sequencer state and the
//   microcode index onto a BedRock header and payload.
//   Ports:
//     i_state      - current sequencer state
//     i_idx        - microcode word index
//     i_ucode_word - microcode word to write
//     o_cmd_v      - high in every command-issuing state
//     o_header     - BedRock header (all zero outside command states)
//     o_data       - command payload
//   Optional feature macro: BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN adds the
//   uncached-read command used for readback.
// -----------------------------------------------------------------------------
module bp_me_cfg_seq_cmd_gen
  import bp_me_cfg_boot_sequencer_pkg::*;
  #(parameter int                        cce_pc_width_p  = 8,
    parameter logic [paddr_width_gp-1:0] cfg_base_addr_p = '0,
    parameter logic [63:0]               npc_p           = boot_base_addr_gp,
    parameter logic [63:0]               lce_mode_p      = 64'(e_lce_mode_normal),
    parameter logic [63:0]               cce_mode_p      = 64'(e_cce_mode_normal))
  (input  bp_cfg_seq_state_e          i_state,
   input  logic [cce_pc_width_p-1:0]  i_idx,
   input  logic [63:0]                i_ucode_word,
   output logic                       o_cmd_v,
   output bp_bedrock_mem_header_s     o_header,
   output logic [63:0]                o_data);

  logic [paddr_width_gp-1:0] w_offset;
  logic [paddr_width_gp-1:0] w_ucode_offset;
  bp_bedrock_mem_type_e      w_type;

  // Each microcode word occupies one 8-byte slot in the match window
  assign w_ucode_offset = cfg_mem_cce_ucode_match_gp + (paddr_width_gp'(i_idx) << 3);

  always_comb begin
    w_offset = '0;
    w_type   = e_bedrock_mem_uc_wr;
    o_data   = '0;
    o_cmd_v  = 1'b1;
    unique case (i_state)
      e_seq_freeze:   begin w_offset = cfg_reg_freeze_gp;      o_data = 64'd1;        end
      e_seq_ucode_wr: begin w_offset = w_ucode_offset;         o_data = i_ucode_word; end
`ifdef BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN
      e_seq_ucode_rd: begin w_offset = w_ucode_offset;         w_type = e_bedrock_mem_uc_rd; end
`endif
      e_seq_icache:   begin w_offset = cfg_reg_icache_mode_gp; o_data = lce_mode_p;   end
      e_seq_dcache:   begin w_offset = cfg_reg_dcache_mode_gp; o_data = lce_mode_p;   end
      e_seq_cce:      begin w_offset = cfg_reg_cce_mode_gp;    o_data = cce_mode_p;   end
      e_seq_npc:      begin w_offset = cfg_reg_npc_gp;         o_data = npc_p;        end
      e_seq_unfreeze: begin w_offset = cfg_reg_freeze_gp;      o_data = 64'd0;        end
      default:        o_cmd_v = 1'b0;
    endcase

    o_header = '0;
    if (o_cmd_v) begin
      o_header.msg_type = w_type;
      o_header.size     = e_bedrock_msg_size_8;
      o_header.addr     = cfg_base_addr_p | w_offset;
    end
  end

endmodule

// File: rtl/bp_me_cfg_boot_sequencer.sv
// -----------------------------------------------------------------------------
// bp_me_cfg_boot_sequencer
//   Headless boot sequencer for one tile's config slice. On start_i it freezes
//   the core, copies CCE microcode from a local ROM into the slice, programs the
//   LCE/CCE modes and the NPC, then unfreezes. One command outstanding at a time.
//   Ports:
//     clk_i, reset_n_i          - clock, asynchronous active-low reset
//     start_i                   - start pulse (only honoured in IDLE)
//     done_o, error_o           - sticky completion / failure flags
//     ucode_addr_o/ucode_data_i - synchronous microcode ROM port
//     mem_cmd_*                 - BedRock command toward the config slice
//     mem_resp_*                - BedRock response from the config slice
//   Optional feature macro: BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN reads every
//   microcode word back after writing it and flags a mismatch as an error.
// -----------------------------------------------------------------------------
module bp_me_cfg_boot_sequencer
  import bp_me_cfg_boot_sequencer_pkg::*;
  #(parameter int                        cce_pc_width_p  = 8,
    parameter int                        ucode_els_p     = 256,
    parameter logic [paddr_width_gp-1:0] cfg_base_addr_p = '0,
    parameter logic [63:0]               npc_p           = boot_base_addr_gp,
    parameter logic [63:0]               lce_mode_p      = 64'(e_lce_mode_normal),
    parameter logic [63:0]               cce_mode_p      = 64'(e_cce_mode_normal),
    parameter int                        timeout_p       = 1024,
    localparam int                       mem_header_width_lp = mem_header_width_gp)
  (input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           start_i,
   output logic                           done_o,
   output logic                           error_o,
   output logic [cce_pc_width_p-1:0]      ucode_addr_o,
   input  logic [63:0]                    ucode_data_i,
   output logic [mem_header_width_lp-1:0] mem_cmd_header_o,
   output logic [63:0]                    mem_cmd_data_o,
   output logic                           mem_cmd_v_o,
   input  logic                           mem_cmd_ready_and_i,
   input  logic [mem_header_width_lp-1:0] mem_resp_header_i,
   input  logic [63:0]                    mem_resp_data_i,
   input  logic                           mem_resp_v_i,
   output logic                           mem_resp_ready_and_o);

  localparam int tmo_width_lp = $clog2(timeout_p) + 1;
  localparam logic [cce_pc_width_p-1:0] ucode_last_lp = cce_pc_width_p'(ucode_els_p - 1);
  localparam logic [tmo_width_lp-1:0]   tmo_last_lp   = tmo_width_lp'(timeout_p - 1);

  // Reset asserts asynchronously, releases two clocks later in step with clk_i
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  bp_cfg_seq_state_e         r_state, w_state_next;
  bp_cfg_seq_state_e         r_ret_state, w_ret_next;
  logic [cce_pc_width_p-1:0] r_idx, w_idx_next;
  logic                      r_bump_idx, w_bump_next;
  bp_bedrock_mem_type_e      r_cmd_type;
  logic [63:0]               r_word;
  logic                      r_have_word;
  logic [tmo_width_lp-1:0]   r_tmo;
  logic                      w_tmo_clr;

  logic                      w_cmd_v;
  logic                      w_cmd_fire;
  bp_bedrock_mem_header_s    w_cmd_header;
  bp_bedrock_mem_header_s    w_resp_header;
  logic [63:0]               w_ucode_word;
  logic                      w_last;
  logic                      w_resp_bad;
  logic                      w_unused_resp;

  // The ROM word is live on the first UCODE_WR cycle; afterwards the captured
  // copy keeps the payload stable under backpressure.
  assign w_ucode_word  = r_have_word ? r_word : ucode_data_i;
  assign w_last        = (r_idx == ucode_last_lp);
  assign w_cmd_fire    = w_cmd_v & mem_cmd_ready_and_i;
  assign w_resp_header = bp_bedrock_mem_header_s'(mem_resp_header_i);
  assign w_unused_resp = ^{mem_resp_header_i, mem_resp_data_i};

`ifdef BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN
  assign w_resp_bad = (w_resp_header.msg_type != r_cmd_type)
                    || ((r_cmd_type == e_bedrock_mem_uc_rd)
                        && (mem_resp_data_i[0+:cce_instr_width_gp] != r_word[0+:cce_instr_width_gp]));
`else
  assign w_resp_bad = (w_resp_header.msg_type != r_cmd_type);
`endif

  bp_me_cfg_seq_cmd_gen
   #(.cce_pc_width_p (cce_pc_width_p),
     .cfg_base_addr_p(cfg_base_addr_p),
     .npc_p          (npc_p),
     .lce_mode_p     (lce_mode_p),
     .cce_mode_p     (cce_mode_p))
   u_cmd_gen
    (.i_state     (r_state),
     .i_idx       (r_idx),
     .i_ucode_word(w_ucode_word),
     .o_cmd_v     (w_cmd_v),
     .o_header    (w_cmd_header),
     .o_data      (mem_cmd_data_o));

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= e_seq_idle;
      r_ret_state <= e_seq_idle;
      r_idx       <= '0;
      r_bump_idx  <= 1'b0;
      r_cmd_type  <= e_bedrock_mem_rd;
      r_word      <= '0;
      r_have_word <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ret_state <= w_ret_next;
      r_idx       <= w_idx_next;
      r_bump_idx  <= w_bump_next;
      if (w_cmd_fire) r_cmd_type <= w_cmd_header.msg_type;
      if (r_state == e_seq_rom) begin
        r_have_word <= 1'b0;
      end else if (r_state == e_seq_ucode_wr) begin
        r_word      <= w_ucode_word;
        r_have_word <= 1'b1;
      end
      if (w_tmo_clr)                  r_tmo <= '0;
      else if (r_state == e_seq_wait) r_tmo <= r_tmo + tmo_width_lp'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret_state;
    w_idx_next   = r_idx;
    w_bump_next  = r_bump_idx;
    w_tmo_clr    = 1'b0;
    unique case (r_state)
      e_seq_idle: if (start_i) w_state_next = e_seq_freeze;
      e_seq_rom:  w_state_next = e_seq_ucode_wr;
      e_seq_wait: begin
        if (mem_resp_v_i) begin
          if (w_resp_bad) begin
            w_state_next = e_seq_error;
          end else begin
            w_state_next = r_ret_state;
            if (r_bump_idx) w_idx_next = r_idx + cce_pc_width_p'(1);
          end
        end else if (r_tmo == tmo_last_lp) begin
          w_state_next = e_seq_error;
        end
      end
      e_seq_done, e_seq_error: w_state_next = r_state;
      default: begin
        // Command-issuing states: hand off to WAIT once the slice accepts
        if (w_cmd_fire) begin
          w_state_next = e_seq_wait;
          w_tmo_clr    = 1'b1;
          w_bump_next  = 1'b0;
          unique case (r_state)
            e_seq_freeze: w_ret_next = e_seq_rom;
`ifdef BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN
            e_seq_ucode_wr: w_ret_next = e_seq_ucode_rd;
            e_seq_ucode_rd: begin
              w_ret_next  = w_last ? e_seq_icache : e_seq_rom;
              w_bump_next = 1'b1;
            end
`else
            e_seq_ucode_wr: begin
              w_ret_next  = w_last ? e_seq_icache : e_seq_rom;
              w_bump_next = 1'b1;
            end
`endif
            e_seq_icache: w_ret_next = e_seq_dcache;
            e_seq_dcache: w_ret_next = e_seq_cce;
            e_seq_cce:    w_ret_next = e_seq_npc;
            e_seq_npc:    w_ret_next = e_seq_unfreeze;
            default:      w_ret_next = e_seq_done;
          endcase
        end
      end
    endcase
  end

  assign done_o               = (r_state == e_seq_done);
  assign error_o              = (r_state == e_seq_error);
  assign ucode_addr_o         = r_idx;
  assign mem_cmd_v_o          = w_cmd_v;
  assign mem_cmd_header_o     = w_cmd_header;
  assign mem_resp_ready_and_o = (r_state == e_seq_wait);

endmodule

// File: tb/tb_bp_me_cfg_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bp_me_cfg_boot_sequencer
//   Directed bench: a small config-slice model answers commands, a ROM model
//   supplies words 0xA0..0xA3, and the initial block walks normal boot,
//   backpressure, timeout, bad response, corrupted microcode and mid-load reset.
// -----------------------------------------------------------------------------
module tb_bp_me_cfg_boot_sequencer;
  import bp_me_cfg_boot_sequencer_pkg::*;

  localparam int          PC_W  = 8;
  localparam int          ELS   = 4;
  localparam int          TMO   = 16;
  localparam logic [63:0] NPC   = 64'h0000_0000_8000_1230;
  localparam int          HW    = mem_header_width_gp;
  localparam logic [39:0] A_NPC = 40'h10;
  localparam logic [39:0] A_UC  = 40'h8000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic            done, error, cmd_v, cmd_ready, resp_v, resp_ready;
  logic [PC_W-1:0] ucode_addr;
  logic [63:0]     ucode_data, cmd_data, resp_data;
  logic [HW-1:0]   cmd_hdr_bits, resp_hdr_bits;
  bp_bedrock_mem_header_s cmd_hdr, resp_hdr;
  bp_bedrock_mem_type_e   resp_type;

  assign cmd_hdr       = bp_bedrock_mem_header_s'(cmd_hdr_bits);
  assign resp_hdr_bits = resp_hdr;
  always_comb begin
    resp_hdr          = '0;
    resp_hdr.msg_type = resp_type;
  end

  bp_me_cfg_boot_sequencer
   #(.cce_pc_width_p(PC_W), .ucode_els_p(ELS), .npc_p(NPC), .timeout_p(TMO))
   dut
    (.clk_i(clk), .reset_n_i(reset_n), .start_i(start),
     .done_o(done), .error_o(error),
     .ucode_addr_o(ucode_addr), .ucode_data_i(ucode_data),
     .mem_cmd_header_o(cmd_hdr_bits), .mem_cmd_data_o(cmd_data),
     .mem_cmd_v_o(cmd_v), .mem_cmd_ready_and_i(cmd_ready),
     .mem_resp_header_i(resp_hdr_bits), .mem_resp_data_i(resp_data),
     .mem_resp_v_i(resp_v), .mem_resp_ready_and_o(resp_ready));

  // Synchronous ROM
  always @(posedge clk)
    ucode_data <= (int'(ucode_addr) < ELS) ? (64'hA0 + 64'(ucode_addr)) : 64'h0;

  // ---------------- config slice model ----------------
  int          bp_cycles  = 0;
  int          drop_idx   = -1;
  logic        bad_npc    = 1'b0;
  logic        corrupt_en = 1'b0;
  int          bp_cnt, n_cmd, n_wr, n_rd, cyc;
  int          acc_cyc [64];
  logic [39:0] wr_addr [32];
  logic [63:0] wr_data [32];
  logic [63:0] ucode_mem [ELS];
  logic [63:0] npc_q;
  logic        stable_ok, in_cmd;
  logic [HW-1:0] first_hdr;
  logic [63:0]   first_data;
  logic [39:0]   c_addr, c_uoff;
  logic          c_is_uc;
  int            c_ui;

  assign cmd_ready = (bp_cnt >= bp_cycles);
  assign c_addr    = cmd_hdr.addr;
  assign c_uoff    = c_addr - A_UC;
  assign c_is_uc   = (c_addr >= A_UC) && (c_addr < A_UC + 40'(8 * ELS));
  assign c_ui      = int'(c_uoff >> 3);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_v <= 1'b0; resp_type <= e_bedrock_mem_rd; resp_data <= '0;
      bp_cnt <= 0; n_cmd <= 0; n_wr <= 0; n_rd <= 0; cyc <= 0;
      stable_ok <= 1'b1; in_cmd <= 1'b0; npc_q <= '0;
      first_hdr <= '0; first_data <= '0;
    end else begin
      cyc <= cyc + 1;
      if (resp_v && resp_ready) resp_v <= 1'b0;
      if (cmd_v && cmd_ready) begin
        if (in_cmd && (cmd_hdr_bits !== first_hdr || cmd_data !== first_data)) stable_ok <= 1'b0;
        if (n_cmd < 64) acc_cyc[n_cmd] <= cyc + 1;
        n_cmd  <= n_cmd + 1;
        in_cmd <= 1'b0;
        bp_cnt <= 0;
        if (cmd_hdr.msg_type == e_bedrock_mem_uc_wr) begin
          if (n_wr < 32) begin wr_addr[n_wr] <= c_addr; wr_data[n_wr] <= cmd_data; end
          n_wr <= n_wr + 1;
          if (c_addr == A_NPC) npc_q <= cmd_data;
          if (c_is_uc) ucode_mem[c_ui] <= (corrupt_en && c_ui == 2) ? 64'hFF : cmd_data;
        end else begin
          n_rd <= n_rd + 1;
        end
        if (n_cmd != drop_idx) begin
          resp_v    <= 1'b1;
          resp_type <= (bad_npc && c_addr == A_NPC) ? e_bedrock_mem_uc_rd : cmd_hdr.msg_type;
          resp_data <= (c_is_uc && cmd_hdr.msg_type == e_bedrock_mem_uc_rd) ? ucode_mem[c_ui] : 64'h0;
        end
      end else if (cmd_v) begin
        bp_cnt <= bp_cnt + 1;
        if (!in_cmd) begin first_hdr <= cmd_hdr_bits; first_data <= cmd_data; in_cmd <= 1'b1; end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_asrt = 0;
  int n_fail = 0;
  logic [39:0] exp_addr [10];
  logic [63:0] exp_data [10];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int k = 0;
    while (!(done || error) && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 128'(done || error), 128'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 128'(n_wr), 128'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 128'(wr_addr[i]), 128'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), 128'(wr_data[i]), 128'(exp_data[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    int k;
    exp_addr[0] = 40'h8;   exp_data[0] = 64'd1;
    for (int i = 0; i < ELS; i++) begin
      exp_addr[1+i] = A_UC + 40'(8 * i);
      exp_data[1+i] = 64'hA0 + 64'(i);
    end
    exp_addr[5] = 40'h200; exp_data[5] = 64'd1;
    exp_addr[6] = 40'h400; exp_data[6] = 64'd1;
    exp_addr[7] = 40'h600; exp_data[7] = 64'd1;
    exp_addr[8] = A_NPC;   exp_data[8] = NPC;
    exp_addr[9] = 40'h8;   exp_data[9] = 64'd0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_done",  128'(done), 128'd0);
    chk("rst_error", 128'(error), 128'd0);
    chk("rst_cmd_v", 128'(cmd_v), 128'd0);
    chk("rst_rready", 128'(resp_ready), 128'd0);
    chk("rst_uaddr", 128'(ucode_addr), 128'd0);
    chk("rst_hdr",   128'(cmd_hdr_bits), 128'd0);
    $display("reset state checked");

    // ---- normal boot ----
    do_reset();
    pulse_start();
    chk("boot_first_v",    128'(cmd_v), 128'd1);
    chk("boot_first_addr", 128'(cmd_hdr.addr), 128'h8);
    chk("boot_first_type", 128'(cmd_hdr.msg_type), 128'(e_bedrock_mem_uc_wr));
    chk("boot_first_size", 128'(cmd_hdr.size), 128'(e_bedrock_msg_size_8));
    wait_end("boot_end", 400);
    chk("boot_done",  128'(done), 128'd1);
    chk("boot_error", 128'(error), 128'd0);
    check_writes("boot");
    chk("boot_npc", 128'(npc_q), 128'(NPC));
    n_before = n_cmd;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("boot_done_ignores_start", 128'(n_cmd), 128'(n_before));
    chk("boot_done_cmd_v", 128'(cmd_v), 128'd0);
    $display("normal boot: %0d writes, npc=0x%0h", n_wr, npc_q);

    // ---- backpressure ----
    bp_cycles = 5;
    do_reset();
    pulse_start();
    wait_end("bp_end", 2000);
    chk("bp_done",   128'(done), 128'd1);
    chk("bp_stable", 128'(stable_ok), 128'd1);
    check_writes("bp");
    bp_cycles = 0;
    $display("backpressure: %0d writes, stable=%0b", n_wr, stable_ok);

    // ---- timeout on third response ----
    drop_idx = 2;
    do_reset();
    pulse_start();
    wait_end("tmo_end", 400);
    chk("tmo_error", 128'(error), 128'd1);
    chk("tmo_latency", 128'(cyc - acc_cyc[2]), 128'(TMO));
    chk("tmo_ncmd", 128'(n_cmd), 128'd3);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("tmo_no_more_cmds", 128'(n_cmd), 128'd3);
    chk("tmo_cmd_v", 128'(cmd_v), 128'd0);
    chk("tmo_done",  128'(done), 128'd0);
    chk("tmo_sticky", 128'(error), 128'd1);
    drop_idx = -1;
    $display("timeout: error after %0d cycles", cyc - acc_cyc[2]);

    // ---- bad response type on NPC write ----
    bad_npc = 1'b1;
    do_reset();
    pulse_start();
    wait_end("bad_end", 400);
    chk("bad_error", 128'(error), 128'd1);
    chk("bad_done",  128'(done), 128'd0);
    chk("bad_nwr",   128'(n_wr), 128'd9);
    bad_npc = 1'b0;
    $display("bad response: error=%0b done=%0b", error, done);

    // ---- corrupted microcode word 2 ----
    corrupt_en = 1'b1;
    do_reset();
    pulse_start();
    wait_end("rb_end", 400);
`ifdef BP_ME_CFG_BOOT_SEQUENCER_READBACK_EN
    chk("rb_error", 128'(error), 128'd1);
    chk("rb_done",  128'(done), 128'd0);
    chk("rb_nrd",   128'(n_rd), 128'd3);
`else
    chk("rb_done",  128'(done), 128'd1);
    chk("rb_error", 128'(error), 128'd0);
`endif
    corrupt_en = 1'b0;
    $display("corrupt word: done=%0b error=%0b reads=%0d", done, error, n_rd);

    // ---- reset during microcode load ----
    do_reset();
    pulse_start();
    k = 0;
    while (n_wr < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_load", 128'(n_wr >= 3), 128'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_done",   128'(done), 128'd0);
    chk("mid_error",  128'(error), 128'd0);
    chk("mid_cmd_v",  128'(cmd_v), 128'd0);
    chk("mid_rready", 128'(resp_ready), 128'd0);
    chk("mid_uaddr",  128'(ucode_addr), 128'd0);
    chk("mid_hdr",    128'(cmd_hdr_bits), 128'd0);
    chk("mid_data",   128'(cmd_data), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start();
    chk("restart_v",    128'(cmd_v), 128'd1);
    chk("restart_addr", 128'(cmd_hdr.addr), 128'h8);
    wait_end("restart_end", 400);
    chk("restart_done", 128'(done), 128'd1);
    check_writes("restart");
    $display("mid-load reset: restart done=%0b writes=%0d", done, n_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
